// File: rtl/spmmio_pkg.sv
// Shared types and helpers for the MMIO slot decoder and its watchdog.
package spmmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;
  localparam int          MAX_SLOT     = 256;

  // Slot-index width; never below one bit so a single-slot build still has a register.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // The wait mask is written MSB-first: its leftmost bit belongs to slot 0.
  function automatic logic wait_bit(input logic [MAX_SLOT-1:0] mask, input int nslot,
                                    input int k);
    return mask[nslot-1-k];
  endfunction

endpackage

// File: rtl/spmmio_watchdog.sv
// Bus watchdog: counts ACCESS cycles and flags the cycle in which the count reaches TIMEOUT.
module spmmio_watchdog
  import spmmio_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TO_BITS-1:0] r_cnt;
  logic [TO_BITS:0]   w_cnt_nxt;

  assign w_cnt_nxt = {1'b0, r_cnt} + 1'b1;
  // Fires in the ACCESS cycle whose closing edge would bring the count to TIMEOUT,
  // so exactly TIMEOUT ACCESS cycles elapse before the abort.
  assign o_expired = i_en && (w_cnt_nxt == (TO_BITS+1)'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= w_cnt_nxt[TO_BITS-1:0];
    end
  end

endmodule

// File: rtl/spmmio_xbar.sv
// Registered MMIO decoder: soft-processor data bus to NSLOT peripheral slots with
// immediate/wait acknowledge, watchdog abort, unmapped-slot errors and an error counter.
module spmmio_xbar
  import spmmio_pkg::*;
#(
  parameter int               NSLOT     = 8,
  parameter int               SEL_BITS  = 8,
  parameter logic [NSLOT-1:0] WAIT_MASK = 8'b00010000,
  parameter int               TIMEOUT   = 255,
  parameter int               TO_BITS   = 8,
  parameter logic [31:0]      ERR_DATA  = ERR_DATA_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:23]           adr_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic [0:3]            sel_i,
  input  logic                  we_i,
  input  logic [0:31]           dat_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [0:31]           dat_o,
  output logic [0:NSLOT-1]      slv_stb,
  output logic [0:21-SEL_BITS]  slv_adr,
  output logic                  slv_we,
  output logic [0:3]            slv_sel,
  output logic [0:31]           slv_dat_w,
  input  logic [0:32*NSLOT-1]   slv_dat_r,
  input  logic [0:NSLOT-1]      slv_ack,
  output logic [7:0]            err_count
);

  localparam int                SLOT_W = clog2(NSLOT);
  localparam logic [SEL_BITS:0] NSLOT_V = (SEL_BITS+1)'(NSLOT);

  state_t                r_state, w_state_nxt;
  logic [SLOT_W-1:0]     r_slot;
  logic [0:21-SEL_BITS]  r_adr;
  logic                  r_we;
  logic [0:3]            r_sel;
  logic [0:31]           r_dat_w;
  logic [0:31]           r_rdata;
  logic                  r_rsp_err;
  logic [7:0]            r_err_cnt;

  logic [SEL_BITS-1:0]   w_sel_idx;
  logic                  w_mapped;
  logic                  w_is_wait;
  logic                  w_ack_sel;
  logic [0:31]           w_rdata;
  logic                  w_expired;
  logic                  w_latch;
  logic                  w_capture;
  logic                  w_rsp_load;
  logic                  w_rsp_err;

  assign w_sel_idx = adr_i[0 +: SEL_BITS];
  assign w_mapped  = ({1'b0, w_sel_idx} < NSLOT_V);
  assign w_is_wait = wait_bit(MAX_SLOT'(WAIT_MASK), NSLOT, int'(r_slot));
  assign w_ack_sel = slv_ack[r_slot];
  assign w_rdata   = slv_dat_r[32*int'(r_slot) +: 32];

  spmmio_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_latch),
    .i_en      (r_state == ST_ACCESS),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_rsp_load  = 1'b0;
    w_rsp_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          w_latch = 1'b1;
          if (w_mapped) begin
            w_state_nxt = ST_ACCESS;
          end else begin
            w_state_nxt = ST_RESP;
            w_rsp_load  = 1'b1;
            w_rsp_err   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // Slave ack is checked before the watchdog so a coincident ack still completes.
        if (!cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_is_wait || w_ack_sel) begin
          w_state_nxt = ST_RESP;
          w_capture   = 1'b1;
          w_rsp_load  = 1'b1;
        end else if (w_expired) begin
          w_state_nxt = ST_RESP;
          w_rsp_load  = 1'b1;
          w_rsp_err   = 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_adr     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_dat_w   <= '0;
      r_rdata   <= '0;
      r_rsp_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_slot  <= w_sel_idx[SLOT_W-1:0];
        r_adr   <= adr_i[SEL_BITS:21];
        r_we    <= we_i;
        r_sel   <= sel_i;
        r_dat_w <= dat_i;
      end
      if (w_capture) begin
        r_rdata <= w_rdata;
      end
      if (w_rsp_load) begin
        r_rsp_err <= w_rsp_err;
      end
      // Counted on entry to an error response, so the count tracks err_o cycles exactly.
      if (w_rsp_load && w_rsp_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    slv_stb = '0;
    if (r_state == ST_ACCESS) begin
      slv_stb[r_slot] = 1'b1;
    end
  end

  assign ack_o     = (r_state == ST_RESP) && !r_rsp_err;
  assign err_o     = (r_state == ST_RESP) && r_rsp_err;
  assign dat_o     = (r_state == ST_RESP) ? (r_rsp_err ? ERR_DATA : r_rdata) : '0;
  assign slv_adr   = r_adr;
  assign slv_we    = r_we;
  assign slv_sel   = r_sel;
  assign slv_dat_w = r_dat_w;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_spmmio_xbar.sv
// Directed bench for spmmio_xbar: immediate, wait, timeout, unmapped, abort, back-to-back and reset.
module tb_spmmio_xbar;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:23]  adr_i;
  logic         cyc_i, stb_i, we_i;
  logic [0:3]   sel_i;
  logic [0:31]  dat_i;
  logic         ack_o, err_o;
  logic [0:31]  dat_o;
  logic [0:7]   slv_stb;
  logic [0:13]  slv_adr;
  logic         slv_we;
  logic [0:3]   slv_sel;
  logic [0:31]  slv_dat_w;
  logic [0:255] slv_dat_r;
  logic [0:7]   slv_ack;
  logic [7:0]   err_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spmmio_xbar dut (
    .clk       (clk),
    .reset     (reset),
    .adr_i     (adr_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .sel_i     (sel_i),
    .we_i      (we_i),
    .dat_i     (dat_i),
    .ack_o     (ack_o),
    .err_o     (err_o),
    .dat_o     (dat_o),
    .slv_stb   (slv_stb),
    .slv_adr   (slv_adr),
    .slv_we    (slv_we),
    .slv_sel   (slv_sel),
    .slv_dat_w (slv_dat_w),
    .slv_dat_r (slv_dat_r),
    .slv_ack   (slv_ack),
    .err_count (err_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    sel_i = '0;   dat_i = '0;   adr_i = '0;
  endtask

  task automatic bus_req(input logic [23:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w;
    sel_i = s;    dat_i = d;    adr_i = a;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got sim time %0t expected finish earlier", $time);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n;
    int errs;
    logic stb_seen;

    reset   = 1'b0;
    bus_idle();
    slv_ack = '0;
    slv_dat_r = '0;
    slv_dat_r[0  +: 32] = 32'h1234_5678;
    slv_dat_r[32 +: 32] = 32'hA1B2_C3D4;
    slv_dat_r[64 +: 32] = 32'h0F1E_2D3C;
    slv_dat_r[96 +: 32] = 32'hDEAD_BEEF;
    tick(); tick();

    check_eq("rst_ack",  32'(ack_o),     32'h0);
    check_eq("rst_err",  32'(err_o),     32'h0);
    check_eq("rst_stb",  32'(slv_stb),   32'h0);
    check_eq("rst_cnt",  32'(err_count), 32'h0);
    check_eq("rst_dat",  dat_o,          32'h0);
    check_eq("rst_adr",  32'(slv_adr),   32'h0);
    check_eq("rst_we",   32'(slv_we),    32'h0);
    check_eq("rst_sel",  32'(slv_sel),   32'h0);
    check_eq("rst_datw", slv_dat_w,      32'h0);
    reset = 1'b1;
    tick();

    // Immediate read, slot 0
    bus_req(24'h00ABCC, 1'b0, 4'hF, 32'h0);
    tick();
    check_eq("imm_stb",    32'(slv_stb), 32'h80);
    check_eq("imm_ack_c1", 32'(ack_o),   32'h0);
    check_eq("imm_adr",    32'(slv_adr), 32'h2AF3);
    tick();
    check_eq("imm_ack",    32'(ack_o),   32'h1);
    check_eq("imm_err",    32'(err_o),   32'h0);
    check_eq("imm_dat",    dat_o,        32'h1234_5678);
    check_eq("imm_stb_dn", 32'(slv_stb), 32'h0);
    tick();
    check_eq("imm_ack_once", 32'(ack_o), 32'h0);
    bus_idle();
    tick();

    // Wait-slot write, slot 3; slot-1 ack must be ignored
    bus_req(24'h031234, 1'b1, 4'b1010, 32'hCAFE_F00D);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("wr_stb",  32'(slv_stb), 32'h10);
      check_eq("wr_datw", slv_dat_w,    32'hCAFE_F00D);
      check_eq("wr_sel",  32'(slv_sel), 32'hA);
      check_eq("wr_adr",  32'(slv_adr), 32'h048D);
      check_eq("wr_we",   32'(slv_we),  32'h1);
      check_eq("wr_noack", 32'(ack_o),  32'h0);
      slv_ack = (i == 4) ? 8'h10 : 8'h40;
      tick();
    end
    check_eq("wr_ack",    32'(ack_o),     32'h1);
    check_eq("wr_err",    32'(err_o),     32'h0);
    check_eq("wr_stb_dn", 32'(slv_stb),   32'h0);
    check_eq("wr_cnt",    32'(err_count), 32'h0);
    slv_ack = '0;
    tick();
    check_eq("wr_ack_once", 32'(ack_o), 32'h0);
    bus_idle();
    tick();

    // Wait-slot read that never acks (other slots acking are ignored)
    bus_req(24'h030000, 1'b0, 4'hF, 32'h0);
    slv_ack = 8'hEF;
    tick();
    n = 0;
    while (slv_stb == 8'h10 && n < 400) begin
      n++;
      tick();
    end
    check_eq("to_cycles", 32'(n),         32'd255);
    check_eq("to_err",    32'(err_o),     32'h1);
    check_eq("to_ack",    32'(ack_o),     32'h0);
    check_eq("to_dat",    dat_o,          32'hFFFF_FFFF);
    check_eq("to_cnt",    32'(err_count), 32'h1);
    slv_ack = '0;
    tick();
    check_eq("to_err_once", 32'(err_o), 32'h0);
    bus_idle();
    tick();

    // cyc_i dropped in the third ACCESS cycle of a wait-slot access
    bus_req(24'h030000, 1'b0, 4'hF, 32'h0);
    tick(); tick(); tick();
    check_eq("ab_stb_on", 32'(slv_stb), 32'h10);
    bus_idle();
    tick();
    check_eq("ab_stb_off", 32'(slv_stb), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_eq("ab_ack", 32'(ack_o), 32'h0);
      check_eq("ab_err", 32'(err_o), 32'h0);
      tick();
    end
    check_eq("ab_cnt", 32'(err_count), 32'h1);

    // Unmapped slot 9, then a long run of back-to-back errors to saturate
    bus_req(24'h090000, 1'b1, 4'hF, 32'h55AA_55AA);
    tick();
    check_eq("um_stb", 32'(slv_stb),   32'h0);
    check_eq("um_err", 32'(err_o),     32'h1);
    check_eq("um_ack", 32'(ack_o),     32'h0);
    check_eq("um_dat", dat_o,          32'hFFFF_FFFF);
    check_eq("um_cnt", 32'(err_count), 32'h2);
    errs = 0;
    stb_seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (err_o) errs++;
      if (slv_stb != 8'h00) stb_seen = 1'b1;
    end
    check_eq("um_errs",    32'(errs),      32'd300);
    check_eq("um_sat",     32'(err_count), 32'hFF);
    check_eq("um_no_stb",  32'(stb_seen),  32'h0);
    bus_idle();
    tick();
    check_eq("um_idle_err", 32'(err_o), 32'h0);

    // Back-to-back immediate reads, slot 1 then slot 2
    bus_req(24'h010000, 1'b0, 4'hF, 32'h0);
    tick();
    check_eq("b2b_stb1", 32'(slv_stb), 32'h40);
    tick();
    check_eq("b2b_ack1", 32'(ack_o), 32'h1);
    check_eq("b2b_dat1", dat_o,      32'hA1B2_C3D4);
    tick();
    check_eq("b2b_gap", 32'(ack_o), 32'h0);
    adr_i = 24'h020000;
    tick();
    check_eq("b2b_stb2", 32'(slv_stb), 32'h20);
    tick();
    check_eq("b2b_ack2", 32'(ack_o), 32'h1);
    check_eq("b2b_dat2", dat_o,      32'h0F1E_2D3C);
    tick();
    bus_idle();
    tick();

    // Reset during a wait-slot ACCESS
    bus_req(24'h030000, 1'b0, 4'hF, 32'h0);
    tick(); tick();
    check_eq("rs_stb_on", 32'(slv_stb), 32'h10);
    reset = 1'b0;
    tick();
    check_eq("rs_stb",  32'(slv_stb),   32'h0);
    check_eq("rs_ack",  32'(ack_o),     32'h0);
    check_eq("rs_err",  32'(err_o),     32'h0);
    check_eq("rs_cnt",  32'(err_count), 32'h0);
    check_eq("rs_dat",  dat_o,          32'h0);
    check_eq("rs_adr",  32'(slv_adr),   32'h0);
    bus_idle();
    reset = 1'b1;
    tick();
    bus_req(24'h000000, 1'b0, 4'hF, 32'h0);
    tick();
    check_eq("rs_idle_stb", 32'(slv_stb), 32'h80);
    tick();
    check_eq("rs_idle_ack", 32'(ack_o), 32'h1);
    check_eq("rs_idle_dat", dat_o,      32'h1234_5678);
    tick();
    bus_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
